idex_ctrl_pipe: RTL and testbench

ID/EX control pipeline stage: it registers the decode-stage control word from the instruction controller into the EX stage. It also detects load-use hazards and inserts bubbles, and it applies branch/jump redirect flushes and memory-stage holds. It sits directly downstream of the controller and upstream of the EX-stage ALU/mux logic and the EX/MEM register.

---
 rtl/idex_ctrl_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_idex_ctrl_pipe.sv | 523 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// idex_ctrl_pipe
// ID/EX control pipeline register. It captures the decode-stage control word
// into the EX stage. It also detects load-use hazards, inserts bubbles,
// applies redirect flushes and freezes the stage while MEM is holding.
//
// Optional feature macro: IDEX_PERF_CNT_EN
//   When defined, the bubble_cnt and flush_cnt performance counters and
//   their ports are added. When undefined, the counters and ports are absent.
//
// The reset port is named "reset", but it is asynchronous and active-low.
// ---------------------------------------------------------------------------
module idex_ctrl_pipe #(
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [3:0]             id_aluctrl,
    input  logic [1:0]             id_alusrca,
    input  logic [1:0]             id_alusrcb,
    input  logic                   id_memwrite,
    input  logic                   id_lunsigned,
    input  logic [1:0]             id_lwhb,
    input  logic [1:0]             id_swhb,
    input  logic                   id_memtoreg,
    input  logic                   id_regwrite,
    input  logic                   id_jal,
    input  logic                   id_jalr,
    input  logic [RFIDX_WIDTH-1:0] id_rd,
    input  logic [RFIDX_WIDTH-1:0] id_rs1,
    input  logic [RFIDX_WIDTH-1:0] id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   redirect,
    input  logic                   hold,
    output logic                   ex_valid,
    output logic [3:0]             ex_aluctrl,
    output logic [1:0]             ex_alusrca,
    output logic [1:0]             ex_alusrcb,
    output logic                   ex_memwrite,
    output logic                   ex_lunsigned,
    output logic [1:0]             ex_lwhb,
    output logic [1:0]             ex_swhb,
    output logic                   ex_memtoreg,
    output logic                   ex_regwrite,
    output logic                   ex_jal,
    output logic                   ex_jalr,
    output logic [RFIDX_WIDTH-1:0] ex_rd,
    output logic                   stall_id,
    output logic                   flush_id
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]            bubble_cnt,
    output logic [31:0]            flush_cnt
`endif
);

    // EX-stage control registers
    logic                   r_exValid;
    logic [3:0]             r_exAluctrl;
    logic [1:0]             r_exAlusrca;
    logic [1:0]             r_exAlusrcb;
    logic                   r_exMemwrite;
    logic                   r_exLunsigned;
    logic [1:0]             r_exLwhb;
    logic [1:0]             r_exSwhb;
    logic                   r_exMemtoreg;
    logic                   r_exRegwrite;
    logic                   r_exJal;
    logic                   r_exJalr;
    logic [RFIDX_WIDTH-1:0] r_exRd;

    // Next-state control word (a bubble unless a real instruction is loaded)
    logic                   w_nxtValid;
    logic [3:0]             w_nxtAluctrl;
    logic [1:0]             w_nxtAlusrca;
    logic [1:0]             w_nxtAlusrcb;
    logic                   w_nxtMemwrite;
    logic                   w_nxtLunsigned;
    logic [1:0]             w_nxtLwhb;
    logic [1:0]             w_nxtSwhb;
    logic                   w_nxtMemtoreg;
    logic                   w_nxtRegwrite;
    logic                   w_nxtJal;
    logic                   w_nxtJalr;
    logic [RFIDX_WIDTH-1:0] w_nxtRd;

    // Hazard and action decode
    logic w_exRdNonZero;
    logic w_rs1Match;
    logic w_rs2Match;
    logic w_loadUse;
    logic w_doFlush;
    logic w_doBubble;
    logic w_doLoad;

    // Load-use detection: the EX instruction is a load whose destination is
    // read by the real instruction currently sitting in ID. x0 never conflicts.
    always_comb begin
        w_exRdNonZero = (r_exRd != '0);
        w_rs1Match    = id_use_rs1 & (id_rs1 == r_exRd);
        w_rs2Match    = id_use_rs2 & (id_rs2 == r_exRd);
        w_loadUse     = r_exValid & r_exMemtoreg & w_exRdNonZero & id_valid
                        & (w_rs1Match | w_rs2Match);
    end

    // Priority resolution: hold beats redirect, redirect beats load-use.
    // A redirect kills the ID instruction, so its hazard no longer matters.
    always_comb begin
        w_doFlush  = ~hold & redirect;
        w_doBubble = ~hold & ~redirect & w_loadUse;
        w_doLoad   = ~hold & ~redirect & ~w_loadUse;
        stall_id   = hold | w_doBubble;
        flush_id   = w_doFlush;
    end

    // Build the word to load. Anything other than a real instruction on the
    // load path becomes an all-zero bubble. Writes to x0 are suppressed here
    // so that the downstream stages never need to check rd themselves.
    always_comb begin
        w_nxtValid     = 1'b0;
        w_nxtAluctrl   = 4'b0000;
        w_nxtAlusrca   = 2'b00;
        w_nxtAlusrcb   = 2'b00;
        w_nxtMemwrite  = 1'b0;
        w_nxtLunsigned = 1'b0;
        w_nxtLwhb      = 2'b00;
        w_nxtSwhb      = 2'b00;
        w_nxtMemtoreg  = 1'b0;
        w_nxtRegwrite  = 1'b0;
        w_nxtJal       = 1'b0;
        w_nxtJalr      = 1'b0;
        w_nxtRd        = '0;
        if (w_doLoad && id_valid) begin
            w_nxtValid     = 1'b1;
            w_nxtAluctrl   = id_aluctrl;
            w_nxtAlusrca   = id_alusrca;
            w_nxtAlusrcb   = id_alusrcb;
            w_nxtMemwrite  = id_memwrite;
            w_nxtLunsigned = id_lunsigned;
            w_nxtLwhb      = id_lwhb;
            w_nxtSwhb      = id_swhb;
            w_nxtMemtoreg  = id_memtoreg;
            w_nxtRegwrite  = id_regwrite & (id_rd != '0);
            w_nxtJal       = id_jal;
            w_nxtJalr      = id_jalr;
            w_nxtRd        = id_rd;
        end
    end

    // EX register: clear on reset, freeze on hold, otherwise take the next word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exValid     <= 1'b0;
            r_exAluctrl   <= 4'b0000;
            r_exAlusrca   <= 2'b00;
            r_exAlusrcb   <= 2'b00;
            r_exMemwrite  <= 1'b0;
            r_exLunsigned <= 1'b0;
            r_exLwhb      <= 2'b00;
            r_exSwhb      <= 2'b00;
            r_exMemtoreg  <= 1'b0;
            r_exRegwrite  <= 1'b0;
            r_exJal       <= 1'b0;
            r_exJalr      <= 1'b0;
            r_exRd        <= '0;
        end else if (!hold) begin
            r_exValid     <= w_nxtValid;
            r_exAluctrl   <= w_nxtAluctrl;
            r_exAlusrca   <= w_nxtAlusrca;
            r_exAlusrcb   <= w_nxtAlusrcb;
            r_exMemwrite  <= w_nxtMemwrite;
            r_exLunsigned <= w_nxtLunsigned;
            r_exLwhb      <= w_nxtLwhb;
            r_exSwhb      <= w_nxtSwhb;
            r_exMemtoreg  <= w_nxtMemtoreg;
            r_exRegwrite  <= w_nxtRegwrite;
            r_exJal       <= w_nxtJal;
            r_exJalr      <= w_nxtJalr;
            r_exRd        <= w_nxtRd;
        end
    end

    assign ex_valid     = r_exValid;
    assign ex_aluctrl   = r_exAluctrl;
    assign ex_alusrca   = r_exAlusrca;
    assign ex_alusrcb   = r_exAlusrcb;
    assign ex_memwrite  = r_exMemwrite;
    assign ex_lunsigned = r_exLunsigned;
    assign ex_lwhb      = r_exLwhb;
    assign ex_swhb      = r_exSwhb;
    assign ex_memtoreg  = r_exMemtoreg;
    assign ex_regwrite  = r_exRegwrite;
    assign ex_jal       = r_exJal;
    assign ex_jalr      = r_exJalr;
    assign ex_rd        = r_exRd;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] r_bubbleCnt;
    logic [31:0] r_flushCnt;

    // Performance counters: load-use bubbles and redirect flushes, both
    // wrapping naturally and frozen while hold is asserted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubbleCnt <= 32'd0;
            r_flushCnt  <= 32'd0;
        end else begin
            if (w_doBubble) begin
                r_bubbleCnt <= r_bubbleCnt + 32'd1;
            end
            if (w_doFlush) begin
                r_flushCnt <= r_flushCnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubbleCnt;
    assign flush_cnt  = r_flushCnt;
`endif

endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_idex_ctrl_pipe
// Self-checking bench for idex_ctrl_pipe. A behavioural model tracks the EX
// control word and the performance counters using the stage's priority rules:
// hold, then redirect, then load-use, then a normal load.
// The counter checks are compiled in only when IDEX_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_idex_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic [3:0] aluctrl;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       memwrite;
        logic       lunsigned;
        logic [1:0] lwhb;
        logic [1:0] swhb;
        logic       memtoreg;
        logic       regwrite;
        logic       jal;
        logic       jalr;
        logic [4:0] rd;
    } ctrl_t;

    logic        clk;
    logic        reset;
    ctrl_t       idWord;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        useRs1;
    logic        useRs2;
    logic        redirect;
    logic        hold;

    logic        ex_valid;
    logic [3:0]  ex_aluctrl;
    logic [1:0]  ex_alusrca;
    logic [1:0]  ex_alusrcb;
    logic        ex_memwrite;
    logic        ex_lunsigned;
    logic [1:0]  ex_lwhb;
    logic [1:0]  ex_swhb;
    logic        ex_memtoreg;
    logic        ex_regwrite;
    logic        ex_jal;
    logic        ex_jalr;
    logic [4:0]  ex_rd;
    logic        stall_id;
    logic        flush_id;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    ctrl_t       exObs;
    ctrl_t       mEx;
    int unsigned mBub;
    int unsigned mFl;
    int          nChecks;
    int          nFails;

    assign exObs = {ex_valid, ex_aluctrl, ex_alusrca, ex_alusrcb, ex_memwrite,
                    ex_lunsigned, ex_lwhb, ex_swhb, ex_memtoreg, ex_regwrite,
                    ex_jal, ex_jalr, ex_rd};

    idex_ctrl_pipe #(.RFIDX_WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (idWord.valid),
        .id_aluctrl   (idWord.aluctrl),
        .id_alusrca   (idWord.alusrca),
        .id_alusrcb   (idWord.alusrcb),
        .id_memwrite  (idWord.memwrite),
        .id_lunsigned (idWord.lunsigned),
        .id_lwhb      (idWord.lwhb),
        .id_swhb      (idWord.swhb),
        .id_memtoreg  (idWord.memtoreg),
        .id_regwrite  (idWord.regwrite),
        .id_jal       (idWord.jal),
        .id_jalr      (idWord.jalr),
        .id_rd        (idWord.rd),
        .id_rs1       (rs1),
        .id_rs2       (rs2),
        .id_use_rs1   (useRs1),
        .id_use_rs2   (useRs2),
        .redirect     (redirect),
        .hold         (hold),
        .ex_valid     (ex_valid),
        .ex_aluctrl   (ex_aluctrl),
        .ex_alusrca   (ex_alusrca),
        .ex_alusrcb   (ex_alusrcb),
        .ex_memwrite  (ex_memwrite),
        .ex_lunsigned (ex_lunsigned),
        .ex_lwhb      (ex_lwhb),
        .ex_swhb      (ex_swhb),
        .ex_memtoreg  (ex_memtoreg),
        .ex_regwrite  (ex_regwrite),
        .ex_jal       (ex_jal),
        .ex_jalr      (ex_jalr),
        .ex_rd        (ex_rd),
        .stall_id     (stall_id),
        .flush_id     (flush_id)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: does the ID instruction depend on a load sitting in EX
    function automatic logic modelLu();
        return mEx.valid && mEx.memtoreg && (mEx.rd != 5'd0) && idWord.valid &&
               ((useRs1 && (rs1 == mEx.rd)) || (useRs2 && (rs2 == mEx.rd)));
    endfunction

    function automatic logic expStall();
        return hold || (!redirect && modelLu());
    endfunction

    function automatic logic expFlush();
        return !hold && redirect;
    endfunction

    function automatic ctrl_t mkInstr(input logic valid, input logic [3:0] alu,
                                      input logic memtoreg, input logic regwrite,
                                      input logic memwrite, input logic [1:0] lwhb,
                                      input logic [1:0] swhb, input logic [4:0] rd);
        ctrl_t c;
        c = '0;
        c.valid    = valid;
        c.aluctrl  = alu;
        c.alusrcb  = 2'b01;
        c.memtoreg = memtoreg;
        c.regwrite = regwrite;
        c.memwrite = memwrite;
        c.lwhb     = lwhb;
        c.swhb     = swhb;
        c.rd       = rd;
        return c;
    endfunction

    // Advance one rising edge and move the model the way the stage should
    task automatic applyStimulus();
        logic lu;
        @(posedge clk);
        lu = modelLu();
        if (!reset) begin
            mEx  = '0;
            mBub = 0;
            mFl  = 0;
        end else if (hold) begin
            mEx = mEx;
        end else if (redirect) begin
            mEx = '0;
            mFl = mFl + 1;
        end else if (lu) begin
            mEx  = '0;
            mBub = mBub + 1;
        end else if (!idWord.valid) begin
            mEx = '0;
        end else begin
            mEx = idWord;
            if (idWord.rd == 5'd0) mEx.regwrite = 1'b0;
        end
        #1;
    endtask

    task automatic setIdle();
        idWord   = '0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        useRs1   = 1'b0;
        useRs2   = 1'b0;
        redirect = 1'b0;
        hold     = 1'b0;
    endtask

    // Reset at start-up, release, first capture, then an asynchronous mid-stream reset
    task automatic test_reset();
        reset = 1'b0;
        setIdle();
        idWord = mkInstr(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd3);
        applyStimulus();
        nChecks++;
        if (exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL reset_state: got %h expected %h", exObs, 24'd0);
        end
        reset = 1'b1;
        applyStimulus();
        nChecks++;
        if (exObs !== mEx) begin
            nFails++;
            $display("[TB] FAIL reset_first_capture: got %h expected %h", exObs, mEx);
        end
        reset = 1'b0;
        mEx = '0;
        mBub = 0;
        mFl = 0;
        #1;
        nChecks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL reset_async: got %h expected %h", exObs, 24'd0);
        end
        #1;
        reset = 1'b1;
        applyStimulus();
        nChecks++;
        if (exObs !== mEx || mEx.valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_recapture: got %h expected %h", exObs, mEx);
        end
    endtask

    // lw x5 in EX, add reading x5 in ID: one bubble then the add advances
    task automatic test_load_use();
        setIdle();
        idWord = mkInstr(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 5'd5);
        applyStimulus();
        idWord = mkInstr(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd6);
        idWord.alusrcb = 2'b00;
        rs1 = 5'd1;
        rs2 = 5'd5;
        useRs1 = 1'b1;
        useRs2 = 1'b1;
        #2;
        nChecks++;
        if (stall_id !== 1'b1 || flush_id !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL lu_stall: got stall=%b flush=%b expected stall=1 flush=0", stall_id, flush_id);
        end
        applyStimulus();
        nChecks++;
        if (exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL lu_bubble: got %h expected %h", exObs, 24'd0);
        end
        #2;
        nChecks++;
        if (stall_id !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL lu_one_cycle: got stall=%b expected 0", stall_id);
        end
        applyStimulus();
        nChecks++;
        if (exObs !== mEx || mEx.rd !== 5'd6) begin
            nFails++;
            $display("[TB] FAIL lu_advance: got %h expected %h", exObs, mEx);
        end
`ifdef IDEX_PERF_CNT_EN
        nChecks++;
        if (bubble_cnt !== 32'd1) begin
            nFails++;
            $display("[TB] FAIL lu_bubble_cnt: got %0d expected 1", bubble_cnt);
        end
`endif
    endtask

    // No stall for rd=0 loads or for register fields that are not read
    task automatic test_no_false_hazard();
        setIdle();
        idWord = mkInstr(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 5'd0);
        applyStimulus();
        idWord = mkInstr(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd7);
        rs1 = 5'd0;
        useRs1 = 1'b1;
        #2;
        nChecks++;
        if (stall_id !== 1'b0 || expStall() !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL nohaz_rd0: got stall=%b expected 0", stall_id);
        end
        idWord = mkInstr(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 5'd5);
        applyStimulus();
        idWord = mkInstr(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd8);
        rs1 = 5'd5;
        useRs1 = 1'b0;
        rs2 = 5'd9;
        useRs2 = 1'b1;
        #2;
        nChecks++;
        if (stall_id !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL nohaz_unused_rs1: got stall=%b expected 0", stall_id);
        end
        applyStimulus();
        nChecks++;
        if (exObs !== mEx) begin
            nFails++;
            $display("[TB] FAIL nohaz_advance: got %h expected %h", exObs, mEx);
        end
    endtask

    // Redirect and load-use in the same cycle: flush wins
    task automatic test_redirect_lu();
        int unsigned bubBefore;
        setIdle();
        idWord = mkInstr(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 5'd5);
        applyStimulus();
        bubBefore = mBub;
        idWord = mkInstr(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd10);
        rs1 = 5'd5;
        useRs1 = 1'b1;
        redirect = 1'b1;
        #2;
        nChecks++;
        if (flush_id !== 1'b1 || stall_id !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL redir_lu_comb: got stall=%b flush=%b expected stall=0 flush=1", stall_id, flush_id);
        end
        applyStimulus();
        nChecks++;
        if (exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL redir_lu_bubble: got %h expected %h", exObs, 24'd0);
        end
`ifdef IDEX_PERF_CNT_EN
        nChecks++;
        if (flush_cnt !== mFl || bubble_cnt !== bubBefore) begin
            nFails++;
            $display("[TB] FAIL redir_lu_cnt: got flush=%0d bubble=%0d expected flush=%0d bubble=%0d",
                     flush_cnt, bubble_cnt, mFl, bubBefore);
        end
`endif
        redirect = 1'b0;
    endtask

    // Hold for three cycles with a pending redirect and a changing ID word
    task automatic test_hold_redirect();
        ctrl_t frozen;
        setIdle();
        idWord = mkInstr(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 5'd12);
        applyStimulus();
        frozen = mEx;
        hold = 1'b1;
        redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idWord = mkInstr(1'b1, 4'(i + 5), 1'b0, 1'b1, 1'b1, 2'b00, 2'(i), 5'd12);
            rs1 = 5'd12;
            useRs1 = 1'b1;
            #2;
            nChecks++;
            if (stall_id !== 1'b1 || flush_id !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL hold_comb_%0d: got stall=%b flush=%b expected stall=1 flush=0", i, stall_id, flush_id);
            end
            applyStimulus();
            nChecks++;
            if (exObs !== frozen || exObs !== mEx) begin
                nFails++;
                $display("[TB] FAIL hold_frozen_%0d: got %h expected %h", i, exObs, frozen);
            end
        end
        hold = 1'b0;
        #2;
        nChecks++;
        if (flush_id !== 1'b1 || stall_id !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL hold_release_comb: got stall=%b flush=%b expected stall=0 flush=1", stall_id, flush_id);
        end
        applyStimulus();
        nChecks++;
        if (exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL hold_release_flush: got %h expected %h", exObs, 24'd0);
        end
        redirect = 1'b0;
    endtask

    // Consecutive redirects each produce a bubble
    task automatic test_back_to_back();
        setIdle();
        redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idWord = mkInstr(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'(i + 1));
            applyStimulus();
            nChecks++;
            if (exObs !== 24'd0) begin
                nFails++;
                $display("[TB] FAIL b2b_redirect_%0d: got %h expected %h", i, exObs, 24'd0);
            end
        end
`ifdef IDEX_PERF_CNT_EN
        nChecks++;
        if (flush_cnt !== mFl) begin
            nFails++;
            $display("[TB] FAIL b2b_flush_cnt: got %0d expected %0d", flush_cnt, mFl);
        end
`endif
        redirect = 1'b0;
    endtask

    // addi x0 drops its write; sh passes store width; invalid words become bubbles
    task automatic test_pass_through();
        setIdle();
        idWord = mkInstr(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 5'd0);
        applyStimulus();
        nChecks++;
        if (ex_valid !== 1'b1 || ex_regwrite !== 1'b0 || exObs !== mEx) begin
            nFails++;
            $display("[TB] FAIL pass_rd0: got %h expected %h", exObs, mEx);
        end
        idWord = mkInstr(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 5'd0);
        applyStimulus();
        nChecks++;
        if (ex_memwrite !== 1'b1 || ex_swhb !== 2'b10 || exObs !== mEx) begin
            nFails++;
            $display("[TB] FAIL pass_sh: got %h expected %h", exObs, mEx);
        end
        idWord = mkInstr(1'b0, 4'd7, 1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 5'd7);
        applyStimulus();
        nChecks++;
        if (exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL pass_invalid: got %h expected %h", exObs, 24'd0);
        end
    endtask

    // Reset asserted while the stage is frozen clears everything at once
    task automatic test_reset_mid_hold();
        setIdle();
        idWord = mkInstr(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 5'd4);
        applyStimulus();
        hold = 1'b1;
        applyStimulus();
        reset = 1'b0;
        mEx = '0;
        mBub = 0;
        mFl = 0;
        #1;
        nChecks++;
        if (exObs !== 24'd0) begin
            nFails++;
            $display("[TB] FAIL reset_mid_hold: got %h expected %h", exObs, 24'd0);
        end
`ifdef IDEX_PERF_CNT_EN
        nChecks++;
        if (bubble_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            nFails++;
            $display("[TB] FAIL reset_cnt: got bubble=%0d flush=%0d expected 0 0", bubble_cnt, flush_cnt);
        end
`endif
        #1;
        reset = 1'b1;
        hold = 1'b0;
    endtask

    // Randomized traffic with small register indices to provoke hazards
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idWord.valid     = ($urandom_range(0, 4) != 0);
            idWord.aluctrl   = 4'($urandom);
            idWord.alusrca   = 2'($urandom);
            idWord.alusrcb   = 2'($urandom);
            idWord.memwrite  = 1'($urandom);
            idWord.lunsigned = 1'($urandom);
            idWord.lwhb      = 2'($urandom);
            idWord.swhb      = 2'($urandom);
            idWord.memtoreg  = 1'($urandom);
            idWord.regwrite  = 1'($urandom);
            idWord.jal       = 1'($urandom);
            idWord.jalr      = 1'($urandom);
            idWord.rd        = 5'($urandom_range(0, 3));
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            useRs1   = 1'($urandom);
            useRs2   = 1'($urandom);
            hold     = ($urandom_range(0, 4) == 0);
            redirect = ($urandom_range(0, 4) == 0);
            #2;
            nChecks++;
            if (stall_id !== expStall() || flush_id !== expFlush()) begin
                nFails++;
                $display("[TB] FAIL rand_comb_%0d: got stall=%b flush=%b expected stall=%b flush=%b",
                         i, stall_id, flush_id, expStall(), expFlush());
            end
            applyStimulus();
            nChecks++;
            if (exObs !== mEx) begin
                nFails++;
                $display("[TB] FAIL rand_ex_%0d: got %h expected %h", i, exObs, mEx);
            end
`ifdef IDEX_PERF_CNT_EN
            nChecks++;
            if (bubble_cnt !== mBub || flush_cnt !== mFl) begin
                nFails++;
                $display("[TB] FAIL rand_cnt_%0d: got bubble=%0d flush=%0d expected bubble=%0d flush=%0d",
                         i, bubble_cnt, flush_cnt, mBub, mFl);
            end
`endif
        end
        setIdle();
    endtask

    // Run every scenario in sequence, then summarize
    initial begin
        nChecks = 0;
        nFails  = 0;
        mEx     = '0;
        mBub    = 0;
        mFl     = 0;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_redirect_lu();
        test_hold_redirect();
        test_back_to_back();
        test_pass_through();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
